// File: rtl/i2c_init_sequencer.sv
// Walks an external {device, register, data} table through the single-write I2C engine,
// with a settle gap after each write. Optional per-write watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_init_sequencer #(
    parameter int NUM_CMDS       = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock_for_sys,
    input  logic        reset,
    input  logic        go,
    output logic [7:0]  cmd_index,
    input  logic [22:0] cmd_entry,
    output logic [6:0]  wr_device_address,
    output logic [7:0]  wr_register_address,
    output logic [7:0]  wr_data,
    output logic        wr_start,
    input  logic        wr_done,
    output logic        busy,
    output logic        all_done,
    output logic        error
);

    // state   | meaning
    // IDLE    | waiting for go with the engine idle
    // LOAD    | latch the table row for cmd_index into wr_*
    // ISSUE   | wr_start high until the engine drops done
    // BUSY    | engine writing; wait for done to return high
    // GAP     | settle delay after a completed write
    // FINISH  | run complete; raise all_done, release busy
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_BUSY,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [7:0]  LAST_IDX = 8'(NUM_CMDS - 1);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] gap_cnt;
    logic        last_row;
    logic        gap_end;
    logic        timeout_hit;

    assign last_row = (cmd_index == LAST_IDX);
    // GAP lasts max(GAP_CYCLES, 1) cycles; a zero load still costs one cycle
    assign gap_end  = (gap_cnt <= 16'd1);

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt;
    logic        error_q;

    assign timeout_hit = ((state == S_ISSUE) || (state == S_BUSY)) &&
                         (({1'b0, to_cnt} + 17'd1) >= TO_LIMIT);

    always_ff @(posedge clock_for_sys) begin
        if (reset) begin
            to_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                to_cnt <= '0;
            end else if (((state == S_ISSUE) || (state == S_BUSY)) && !timeout_hit) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if ((state == S_IDLE) && go && wr_done) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clock_for_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go && wr_done) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end else if (!wr_done) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end else if (wr_done) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nxt = last_row ? S_FINISH : S_LOAD;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Decoded from state so the start strobe drops on the same edge that leaves ISSUE
    always_comb begin
        wr_start = (state == S_ISSUE);
    end

    always_ff @(posedge clock_for_sys) begin
        if (reset) begin
            cmd_index           <= '0;
            wr_device_address   <= '0;
            wr_register_address <= '0;
            wr_data             <= '0;
            busy                <= 1'b0;
            all_done            <= 1'b0;
            gap_cnt             <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go && wr_done) begin
                        busy      <= 1'b1;
                        all_done  <= 1'b0;
                        cmd_index <= '0;
                    end
                end
                S_LOAD: begin
                    wr_device_address   <= cmd_entry[22:16];
                    wr_register_address <= cmd_entry[15:8];
                    wr_data             <= cmd_entry[7:0];
                end
                S_ISSUE, S_BUSY: begin
                    if (timeout_hit) begin
                        busy <= 1'b0;
                    end else if ((state == S_BUSY) && wr_done) begin
                        gap_cnt <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        gap_cnt <= '0;
                        if (!last_row) begin
                            cmd_index <= cmd_index + 8'd1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                S_FINISH: begin
                    busy      <= 1'b0;
                    all_done  <= 1'b1;
                    cmd_index <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
